// File: rtl/ahb_modport_slave.sv
// AHB-Lite memory slave with byte-lane writes, configurable wait states and
// two-cycle ERROR responses.
//
// Parameters
//   ADDR_W      : HADDR width
//   DATA_W      : data bus width (32 or 64)
//   MEM_WORDS   : memory depth in DATA_W words
//   WAIT_STATES : wait cycles inserted in every OKAY data phase (0..15)
//
// Ports
//   HCLK, HRESETn        : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE        : address-phase control
//   HBURST, HPROT        : accepted but ignored
//   HWDATA               : write data (data phase)
//   HREADY               : global ready, qualifies address-phase acceptance
//   HREADYOUT, HRESP,
//   HRDATA               : slave response, decoded from registered state only
module ahb_modport_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_WAIT,
    PH_DONE,
    PH_ERR1,
    PH_ERR2
  } phase_t;

  phase_t            phase;
  logic [3:0]        wait_cnt;
  logic              write_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LSB-1:0]    off_q;
  logic [2:0]        size_q;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic              accept;
  logic              bad_range;
  logic              bad_align;
  logic              bad_size;
  logic              xfer_err;
  logic [63:0]       addr_ext;
  logic [NB-1:0]     be;

  // Address-phase decode
  always_comb begin
    addr_ext  = 64'(HADDR);
    accept    = HSEL && HREADY && HTRANS[1];
    bad_range = addr_ext >= (64'(MEM_WORDS) * 64'(NB));
    bad_align = (addr_ext & ((64'd1 << HSIZE) - 64'd1)) != 64'd0;
    bad_size  = 32'(HSIZE) > LSB;
    xfer_err  = bad_range || bad_align || bad_size;
  end

  // Phase sequencing; the next address phase is taken from any ready phase
  // (idle, completion or second error cycle), which gives zero-bubble pipelining.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      phase    <= PH_IDLE;
      wait_cnt <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
    end else begin
      case (phase)
        PH_WAIT: begin
          if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            phase    <= PH_DONE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        PH_ERR1: phase <= PH_ERR2;
        default: begin
          if (accept) begin
            write_q  <= HWRITE;
            idx_q    <= addr_ext[LSB +: IDX_W];
            off_q    <= addr_ext[LSB-1:0];
            size_q   <= HSIZE;
            wait_cnt <= '0;
            if (xfer_err)
              phase <= PH_ERR1;
            else if (WAIT_STATES == 0)
              phase <= PH_DONE;
            else
              phase <= PH_WAIT;
          end else begin
            phase <= PH_IDLE;
          end
        end
      endcase
    end
  end

  // Little-endian byte lanes covered by the latched size/offset
  always_comb begin
    int unsigned lo;
    int unsigned hi;
    lo = 32'(off_q);
    hi = lo + (32'd1 << size_q);
    be = '0;
    for (int unsigned b = 0; b < NB; b++)
      be[b] = (b >= lo) && (b < hi);
  end

  // Memory has no reset; an async reset forces PH_IDLE, so a pending write
  // never reaches the array.
  always_ff @(posedge HCLK) begin
    if (phase == PH_DONE && write_q) begin
      for (int unsigned b = 0; b < NB; b++)
        if (be[b])
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

  assign HREADYOUT = !(phase == PH_WAIT || phase == PH_ERR1);
  assign HRESP     = (phase == PH_ERR1 || phase == PH_ERR2) ? 2'b01 : 2'b00;
  // Read port follows the write port, so read-after-write sees fresh data
  assign HRDATA    = (phase == PH_DONE && !write_q) ? mem[idx_q] : '0;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb_modport_slave.sv
// Scoreboard bench for ahb_modport_slave: instance 0 has no wait states,
// instance 1 has two. The driver pushes expected responses on acceptance; a
// negedge monitor pops and compares whenever a data phase completes.
module tb_ahb_modport_slave;

  localparam int WS1 = 2;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        clk;
  logic        hresetn [2];
  logic        hsel    [2];
  logic [31:0] haddr   [2];
  logic [1:0]  htrans  [2];
  logic        hwrite  [2];
  logic [2:0]  hsize   [2];
  logic [31:0] hwdata  [2];

  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rdata0, rdata1;

  exp_t sb0[$];
  exp_t sb1[$];
  int   wcnt    [2];
  bit   errseen [2];
  int   checks;
  int   errors;

  ahb_modport_slave #(
    .ADDR_W(32), .DATA_W(32), .MEM_WORDS(64), .WAIT_STATES(0)
  ) dut0 (
    .HCLK(clk), .HRESETn(hresetn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000),
    .HPROT(4'b0011), .HWDATA(hwdata[0]), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_modport_slave #(
    .ADDR_W(32), .DATA_W(32), .MEM_WORDS(64), .WAIT_STATES(WS1)
  ) dut1 (
    .HCLK(clk), .HRESETn(hresetn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b001),
    .HPROT(4'b0011), .HWDATA(hwdata[1]), .HREADY(rdy1),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (rdy,resp,rdata)", name, d, act, exp);
    end
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(sb0.pop_front());
    else        void'(sb1.pop_front());
  endtask

  task automatic mon_step(input int d);
    exp_t        e;
    bit          have;
    logic [34:0] act;
    act  = (d == 0) ? {rdy0, resp0, rdata0} : {rdy1, resp1, rdata1};
    have = 1'b0;
    if (d == 0 && sb0.size() > 0) begin have = 1'b1; e = sb0[0]; end
    if (d == 1 && sb1.size() > 0) begin have = 1'b1; e = sb1[0]; end
    if (!have) begin
      chk("idle", d, act, {1'b1, 2'b00, 32'h0});
    end else if (e.err) begin
      if (!errseen[d]) begin
        chk("err_cycle1", d, act, {1'b0, 2'b01, 32'h0});
        errseen[d] = 1'b1;
      end else begin
        chk("err_cycle2", d, act, {1'b1, 2'b01, 32'h0});
        errseen[d] = 1'b0;
        sb_pop(d);
      end
    end else if (!act[34]) begin
      chk("wait", d, act, {1'b0, 2'b00, 32'h0});
      wcnt[d]++;
      if (wcnt[d] > 20) begin
        chk("wait_bound", d, 35'(wcnt[d]), 35'(e.waits));
        wcnt[d] = 0;
        sb_pop(d);
      end
    end else begin
      chk("wait_count", d, 35'(wcnt[d]), 35'(e.waits));
      chk("complete", d, act, {1'b1, 2'b00, e.rdata});
      wcnt[d] = 0;
      sb_pop(d);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // Address phase; returns #1 after the accepting edge with HWDATA driven
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                      output int cyc);
    bit   rdy;
    exp_t e;
    cyc       = 0;
    hsel[d]   = 1'b1;
    haddr[d]  = a;
    htrans[d] = 2'b10;
    hwrite[d] = wr;
    hsize[d]  = sz;
    do begin
      @(negedge clk);
      rdy = (d == 0) ? rdy0 : rdy1;
      @(posedge clk);
      cyc++;
    end while (!rdy && cyc < 50);
    if (!rdy) chk("accept_timeout", d, 35'(cyc), 35'd0);
    e.err   = exp_err;
    e.rdata = (wr || exp_err) ? 32'h0 : exp_rd;
    e.waits = (exp_err || d == 0) ? 0 : WS1;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    #1;
    hwdata[d] = wd;
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
  endtask

  task automatic idle(input int d, input int n);
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    clk    = 1'b0;
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      hresetn[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = '0; wcnt[d] = 0; errseen[d] = 1'b0;
    end
    #1;
    chk("reset_outputs", 0, {rdy0, resp0, rdata0}, {1'b1, 2'b00, 32'h0});
    chk("reset_outputs", 1, {rdy1, resp1, rdata1}, {1'b1, 2'b00, 32'h0});
    repeat (3) @(posedge clk);
    #1;
    hresetn[0] = 1'b1;
    hresetn[1] = 1'b1;

    // No wait states: back-to-back RAW, byte/halfword lanes, error cases
    xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0,        0, cyc);
    xfer(0, 0, 32'h10, 3'd2, 32'h0,        32'hDEADBEEF, 0, cyc);
    xfer(0, 1, 32'h10, 3'd2, 32'h11223344, 32'h0,        0, cyc);
    xfer(0, 1, 32'h13, 3'd0, 32'hAA000000, 32'h0,        0, cyc);
    xfer(0, 0, 32'h10, 3'd2, 32'h0,        32'hAA223344, 0, cyc);
    xfer(0, 1, 32'h20, 3'd2, 32'h55667788, 32'h0,        0, cyc);
    xfer(0, 1, 32'h22, 3'd1, 32'hBEEF0000, 32'h0,        0, cyc);
    xfer(0, 0, 32'h20, 3'd2, 32'h0,        32'hBEEF7788, 0, cyc);
    xfer(0, 1, 32'h11, 3'd1, 32'hFFFFFFFF, 32'h0,        1, cyc);
    xfer(0, 0, 32'h10, 3'd2, 32'h0,        32'hAA223344, 0, cyc);
    xfer(0, 0, 32'h100, 3'd2, 32'h0,       32'h0,        1, cyc);
    xfer(0, 0, 32'h18, 3'd3, 32'h0,        32'h0,        1, cyc);
    xfer(0, 1, 32'hFC, 3'd2, 32'hCAFEF00D, 32'h0,        0, cyc);
    xfer(0, 0, 32'hFC, 3'd2, 32'h0,        32'hCAFEF00D, 0, cyc);
    xfer(0, 0, 32'h12, 3'd0, 32'h0,        32'hAA223344, 0, cyc);
    idle(0, 2);
    // Unselected NONSEQ and selected BUSY start no data phase
    hsel[0] = 1'b0; htrans[0] = 2'b10; haddr[0] = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    hsel[0] = 1'b1; htrans[0] = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    idle(0, 2);

    // Two wait states
    xfer(1, 1, 32'h08, 3'd2, 32'h12345678, 32'h0,        0, cyc);
    xfer(1, 0, 32'h08, 3'd2, 32'h0,        32'h12345678, 0, cyc);
    xfer(1, 1, 32'h11, 3'd1, 32'hFFFFFFFF, 32'h0,        1, cyc);
    xfer(1, 0, 32'h08, 3'd2, 32'h0,        32'h12345678, 0, cyc);
    idle(1, 6);

    // Reset during a write's wait state drops the write
    xfer(1, 1, 32'h08, 3'd2, 32'h00009999, 32'h0, 0, cyc);
    #1;
    hresetn[1] = 1'b0;
    #1;
    chk("reset_mid_xfer", 1, {rdy1, resp1, rdata1}, {1'b1, 2'b00, 32'h0});
    sb1.delete();
    wcnt[1]    = 0;
    errseen[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hresetn[1] = 1'b1;
    xfer(1, 0, 32'h08, 3'd2, 32'h0, 32'h12345678, 0, cyc);
    chk("accept_first_edge", 1, 35'(cyc), 35'd1);
    idle(1, 2);

    for (int i = 0; i < 200 && (sb0.size() > 0 || sb1.size() > 0); i++) @(posedge clk);
    chk("drain", 0, 35'(sb0.size() + sb1.size()), 35'd0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_modport_slave.md
AHB_MODPORT_SLAVE -- requirements
Module: ahb_modport_slave

Interface
REQ-001 Parameter ADDR_W, default 32: HADDR width.
REQ-002 Parameter DATA_W, default 32: data bus width, 32 or 64 only.
REQ-003 Parameter MEM_WORDS, default 1024: memory depth in DATA_W words; byte range 0 .. MEM_WORDS*DATA_W/8-1.
REQ-004 Parameter WAIT_STATES, default 0: wait cycles inserted in every OKAY data phase, 0..15.
REQ-005 HCLK  in  1: clock; all logic on rising edge.
REQ-006 HRESETn  in  1: reset; one clock; reset is asynchronous and active-low.
REQ-007 HSEL  in  1: slave select.
REQ-008 HADDR  in  ADDR_W: byte address.
REQ-009 HTRANS  in  2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 HWRITE  in  1: 1=write.
REQ-011 HSIZE  in  3: bytes = 2**HSIZE.
REQ-012 HBURST  in  3: ignored; each beat is decoded independently.
REQ-013 HPROT  in  4: ignored.
REQ-014 HWDATA  in  DATA_W: write data, data phase.
REQ-015 HREADY  in  1: global ready; gates address-phase acceptance.
REQ-016 HREADYOUT  out  1: slave ready.
REQ-017 HRESP  out  2: OKAY=00, ERROR=01; 10/11 never driven.
REQ-018 HRDATA  out  DATA_W: read data.

Function
REQ-019 Transfer accepted at a rising edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ.
- HADDR, HWRITE and HSIZE are registered at acceptance.
- IDLE, BUSY or HSEL=0 starts no data phase; the next cycle drives HREADYOUT=1, HRESP=OKAY.
REQ-020 Error conditions, evaluated at acceptance:
- address beyond memory range;
- HADDR not aligned to 2**HSIZE;
- 2**HSIZE > DATA_W/8.
REQ-021 ERROR response, no wait states:
- cycle 1: HRESP=01, HREADYOUT=0;
- cycle 2: HRESP=01, HREADYOUT=1;
- memory is never modified.
REQ-022 OKAY data phase: WAIT_STATES cycles with HREADYOUT=0, HRESP=00, then one completion cycle with HREADYOUT=1, HRESP=00.
REQ-023 Write: in the completion cycle, HWDATA byte lanes selected by HSIZE and HADDR low bits (little-endian) are written at that clock edge; other bytes are unchanged.
REQ-024 Read: HRDATA carries the full addressed word in the completion cycle only; HRDATA=0 in all other cycles.
REQ-025 Pipelining: a new address phase presented in a completion cycle (HREADY=1) is accepted, giving zero-bubble back-to-back transfers.
- Address phases presented while HREADY=0 are ignored.
REQ-026 Read-after-write to the same address in consecutive transfers returns the newly written data.
REQ-027 Memory array is not reset; contents are undefined until written.
REQ-028 Only registered state (phase state, wait counter, latched control) drives the outputs; no combinational path from inputs to outputs.

Reset
REQ-029 While HRESETn=0: HREADYOUT=1, HRESP=00, HRDATA=0, wait counter=0, no pending data phase.
REQ-030 Reset asserted mid-transfer abandons the transfer; a pending write is not performed.
REQ-031 After deassertion, the first rising edge may accept a transfer.

Verification
REQ-032 WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then word read @0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 each data phase, HRESP=00.
REQ-033 Byte write 0xAA @0x13 over word 0x11223344 @0x10 -> word read returns 0xAA223344.
REQ-034 WAIT_STATES=2 read -> HREADYOUT low for exactly 2 cycles, then high with data.
REQ-035 Halfword access @0x11 -> HRESP=01 for two cycles, HREADYOUT 0 then 1; a later read shows memory unchanged.
REQ-036 Read at MEM_WORDS*4 -> two-cycle ERROR response.
REQ-037 HRESETn low during a wait state -> outputs return to reset values at once; the pending write is lost.
